// File: rtl/scale_skid_reg.sv
// Two-entry skid register (main + skid) with a valid/ready handshake on both sides.
// Optional stall counter on stall_cnt, enabled by defining SKID_STALL_CNT_EN.
module scale_skid_reg #(
   parameter int WIDTH = 5
`ifdef SKID_STALL_CNT_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef SKID_STALL_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

   state_t           state_p0;
   logic [WIDTH-1:0] main_p0;
   logic [WIDTH-1:0] skid_p0;
   logic             vld_p0;
   logic             rdy_p0;
   logic             accept;
   logic             take;

   assign in_ready  = rdy_p0;
   assign out_valid = vld_p0;
   assign out_data  = main_p0;
   assign accept    = in_valid & rdy_p0;
   assign take      = vld_p0 & out_ready;

   // Stage p0: handshake FSM; vld_p0/rdy_p0 are registered images of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= EMPTY;
         main_p0  <= '0;
         skid_p0  <= '0;
         vld_p0   <= 1'b0;
         rdy_p0   <= 1'b1;
      end else if (flush) begin
         state_p0 <= EMPTY;
         vld_p0   <= 1'b0;
         rdy_p0   <= 1'b1;
      end else begin
         case (state_p0)
            EMPTY: begin
               if (accept) begin
                  main_p0  <= in_data;
                  state_p0 <= BUSY;
                  vld_p0   <= 1'b1;
                  rdy_p0   <= 1'b1;
               end
            end
            BUSY: begin
               if (accept && take) begin
                  main_p0  <= in_data;
               end else if (accept) begin
                  skid_p0  <= in_data;
                  state_p0 <= FULL;
                  rdy_p0   <= 1'b0;
               end else if (take) begin
                  state_p0 <= EMPTY;
                  vld_p0   <= 1'b0;
               end
            end
            FULL: begin
               if (take) begin
                  main_p0  <= skid_p0;
                  state_p0 <= BUSY;
                  rdy_p0   <= 1'b1;
               end
            end
            default: begin
               state_p0 <= EMPTY;
               vld_p0   <= 1'b0;
               rdy_p0   <= 1'b1;
            end
         endcase
      end
   end

`ifdef SKID_STALL_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Stage p0: stall counter, counts cycles the head word is offered but refused
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (flush) begin
         stall_cnt <= '0;
      end else if (vld_p0 && !out_ready) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_scale_skid_reg.sv
// Self-checking bench for scale_skid_reg (WIDTH=5; CNT_W=3 when SKID_STALL_CNT_EN is defined).
module tb_scale_skid_reg;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] out_data;

   int checks = 0;
   int errors = 0;

`ifdef SKID_STALL_CNT_EN
   logic [2:0] stall_cnt;
   scale_skid_reg #(.WIDTH(5), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt));
`else
   scale_skid_reg #(.WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
`endif

   always #5 clk = ~clk;

   // Behavioural model: a FIFO of at most two words plus a saturating stall count
   logic [4:0] mq[$];
   int         mcnt = 0;
   logic [4:0] dut_log[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mcnt = 0;
      end else begin
         automatic bit acc = in_valid && (mq.size() < 2);
         automatic bit tk  = (mq.size() > 0) && out_ready;
         if (flush) begin
            mq.delete();
            mcnt = 0;
         end else begin
            if (mq.size() > 0 && !out_ready && mcnt < 7) mcnt = mcnt + 1;
            if (tk) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus a log of words the DUT hands over
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
         chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != 2});
         if (mq.size() != 0) chk("out_data", {27'd0, out_data}, {27'd0, mq[0]});
`ifdef SKID_STALL_CNT_EN
         chk("stall_cnt", {29'd0, stall_cnt}, mcnt);
`endif
         if (out_valid && out_ready) dut_log.push_back(out_data);
      end
   end

   task automatic cyc(input logic iv, input logic [4:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string name, input logic [4:0] exp[$]);
      chk({name, "_len"}, dut_log.size(), exp.size());
      foreach (exp[i]) begin
         if (i < dut_log.size()) chk(name, {27'd0, dut_log[i]}, {27'd0, exp[i]});
      end
      dut_log.delete();
   endtask

   initial begin
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", {27'd0, out_data}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);

      // pass-through, one word per cycle
      dut_log.delete();
      cyc(1, 5'b00001, 1, 0);
      chk("pt_lat0", {26'd0, out_valid, out_data}, {26'd0, 1'b1, 5'b00001});
      cyc(1, 5'b10001, 1, 0);
      chk("pt_lat1", {26'd0, out_valid, out_data}, {26'd0, 1'b1, 5'b10001});
      cyc(1, 5'b11111, 1, 0);
      chk("pt_lat2", {26'd0, out_valid, out_data}, {26'd0, 1'b1, 5'b11111});
      cyc(0, 0, 1, 0);
      chk("pt_drain", {31'd0, out_valid}, 32'd0);
      chk_log("pt_order", '{5'b00001, 5'b10001, 5'b11111});

      // back-pressure into FULL, then drain in order
      cyc(1, 5'b00001, 0, 0);
      cyc(1, 5'b10101, 0, 0);
      chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_full_head", {27'd0, out_data}, 32'd1);
      cyc(1, 5'b11111, 0, 0);
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
      cyc(1, 5'b11111, 1, 0);
      chk("bp_head2", {27'd0, out_data}, {27'd0, 5'b10101});
      cyc(1, 5'b11111, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      chk_log("bp_order", '{5'b00001, 5'b10101, 5'b11111});

      // stall hold and stall counter saturation
      cyc(0, 0, 0, 1);
      cyc(1, 5'b01001, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0);
         chk("stall_hold", {26'd0, out_valid, out_data}, {26'd0, 1'b1, 5'b01001});
      end
`ifdef SKID_STALL_CNT_EN
      chk("stall_cnt4", {29'd0, stall_cnt}, 32'd4);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
      chk("stall_sat", {29'd0, stall_cnt}, 32'd7);
`endif
      cyc(0, 0, 0, 1);
      chk("stall_flush_vld", {31'd0, out_valid}, 32'd0);
`ifdef SKID_STALL_CNT_EN
      chk("stall_flush_cnt", {29'd0, stall_cnt}, 32'd0);
`endif
      dut_log.delete();

      // flush from FULL while upstream offers a word
      cyc(1, 5'b00001, 0, 0);
      cyc(1, 5'b10101, 0, 0);
      cyc(1, 5'b11111, 0, 1);
      chk("fl_vld", {31'd0, out_valid}, 32'd0);
      chk("fl_rdy", {31'd0, in_ready}, 32'd1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      chk_log("fl_none", '{});

      // flush in BUSY with accept and take together: accepted word dropped
      cyc(1, 5'b00011, 0, 0);
      cyc(1, 5'b00101, 1, 1);
      dut_log.delete();
      chk("fl2_vld", {31'd0, out_valid}, 32'd0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      chk_log("fl2_none", '{});

      // asynchronous reset while FULL
      cyc(1, 5'b00111, 0, 0);
      cyc(1, 5'b01000, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_out_data", {27'd0, out_data}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dut_log.delete();
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      chk("arst_after", {31'd0, out_valid}, 32'd0);
      chk_log("arst_none", '{});

      // resume after reset
      cyc(1, 5'b10000, 1, 0);
      chk("resume", {26'd0, out_valid, out_data}, {26'd0, 1'b1, 5'b10000});
      cyc(0, 0, 1, 0);
      chk_log("resume_log", '{5'b10000});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
